mod_counter: RTL

- Parametrised successor to the team's fixed 4-bit free-running counter.
- Configurable width, modulus, reset value and prescaler.
- Adds up/down counting, enable, synchronous clear and parallel load, wrap or saturate mode, terminal-count, overflow and compare-match flags.
- Used as the general counting primitive in lab tasks: timers, BCD digits, clock dividers. Counters cascade through tc/ovf.

---
 rtl/mod_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mod_counter.sv
// Parametrised up/down modulus counter with optional prescaler, wrap or
// saturate boundary handling, and tc/ovf/match/step flags for cascading.
module mod_counter #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 64'd0,
  parameter int              SATURATE  = 0,
  parameter int              PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] result,
  output logic             tc,
  output logic             ovf,
  output logic             match,
  output logic             step
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("mod_counter: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
      $error("mod_counter: RESET_VAL=%0d exceeds MAX_VAL=%0d", RESET_VAL, MAX_VAL);
    end
    if (SATURATE < 0 || SATURATE > 1) begin : g_bad_sat
      $error("mod_counter: SATURATE=%0d must be 0 or 1", SATURATE);
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("mod_counter: PRESCALE=%0d must be >= 1", PRESCALE);
    end
  endgenerate

  localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_C  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  logic [WIDTH-1:0] result_r;
  logic             ovf_r;
  logic             pre_last_s;
  logic             step_s;
  logic             tc_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Prescaler: counts enabled cycles and flags the last one of each period
  generate
    if (PRESCALE > 1) begin : g_pre
      logic [PW-1:0] pre_r;

      // Advance on enabled cycles, restart on reset/clear/load or after a step
      always_ff @(posedge clk) begin
        if (reset || clear || load) begin
          pre_r <= {PW{1'b0}};
        end else if (en) begin
          pre_r <= pre_last_s ? {PW{1'b0}} : pre_r + PW'(1'b1);
        end else begin
          pre_r <= pre_r;
        end
      end

      assign pre_last_s = (pre_r == PW'(PRESCALE - 1));
    end else begin : g_nopre
      assign pre_last_s = 1'b1;
    end
  endgenerate

  assign step_s       = en & pre_last_s & ~clear & ~load & ~reset;
  assign tc_s         = up_dn ? (result_r == MAX_C) : (result_r == ZERO_C);
  assign load_clamp_s = (load_val > MAX_C) ? MAX_C : load_val;

  // Next count value; the boundary is handled explicitly so a modulus below
  // 2**WIDTH wraps correctly
  always_comb begin
    next_s = result_r;
    if (up_dn) begin
      if (result_r == MAX_C) begin
        next_s = (SATURATE != 0) ? MAX_C : ZERO_C;
      end else begin
        next_s = result_r + ONE_C;
      end
    end else begin
      if (result_r == ZERO_C) begin
        next_s = (SATURATE != 0) ? ZERO_C : MAX_C;
      end else begin
        next_s = result_r - ONE_C;
      end
    end
  end

  // Count register and boundary pulse: reset > clear > load > count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      result_r <= RST_C;
      ovf_r    <= 1'b0;
    end else if (load) begin
      result_r <= load_clamp_s;
      ovf_r    <= 1'b0;
    end else begin
      if (step_s) begin
        result_r <= next_s;
      end else begin
        result_r <= result_r;
      end
      ovf_r <= step_s & tc_s;
    end
  end

  assign result = result_r;
  assign ovf    = ovf_r;
  assign tc     = tc_s;
  assign match  = (result_r == cmp_val);
  assign step   = step_s;

endmodule
